// File: rtl/imem_fetch_ctrl_if.sv
// Decode-side fetch handshake bundle.
// The fetch unit is the master; decode is the slave.
interface imem_fetch_ctrl_if #(
  parameter int AWL = 6,
  parameter int DWL = 32
);
  logic           IF_VALID;
  logic           IF_READY;
  logic [DWL-1:0] IF_INSTR;
  logic [AWL-1:0] IF_PC;

  modport master (
    output IF_VALID,
    output IF_INSTR,
    output IF_PC,
    input  IF_READY
  );

  modport slave (
    input  IF_VALID,
    input  IF_INSTR,
    input  IF_PC,
    output IF_READY
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer with a 2-entry buffer.
// Owns the PC, handles redirect flush and halt/drain.
module imem_fetch_ctrl #(
  parameter int             AWL      = 6,
  parameter int             DWL      = 32,
  parameter logic [AWL-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [AWL-1:0]   IMA,
  input  logic [DWL-1:0]   IMRD,
  imem_fetch_ctrl_if.master dec,
  input  logic             REDIRECT,
  input  logic [AWL-1:0]   REDIRECT_PC,
  input  logic             HALT_REQ,
  output logic             HALTED
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t         r_state;
  logic           r_halted;
  logic [AWL-1:0] r_pc;
  logic [1:0]     r_cnt;
  logic           r_head;
  logic [AWL-1:0] r_bpc   [2];
  logic [DWL-1:0] r_binstr [2];

  logic           w_valid;
  logic           w_pop;
  logic           w_push;
  logic           w_tail;
  logic [1:0]     w_cnt_nxt;
  state_t         w_state_nxt;

  assign w_valid = (r_cnt != 2'd0);
  assign w_pop   = w_valid & dec.IF_READY;
  assign w_tail  = r_head ^ r_cnt[0];

  // Fetch when running and either a slot is free or one is leaving.
  always_comb begin
    w_push = 1'b0;
    if (r_state == S_RUN && !REDIRECT && !HALT_REQ)
      w_push = (r_cnt < 2'd2) | w_pop;
  end

  // Occupancy after this cycle; a redirect flushes everything.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (REDIRECT)
      w_cnt_nxt = 2'd0;
    else
      w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  end

  // Halt/drain sequencing.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN: begin
        if (HALT_REQ)
          w_state_nxt = (w_cnt_nxt != 2'd0) ? S_DRAIN : S_HALT;
      end
      S_DRAIN: begin
        if (!HALT_REQ)
          w_state_nxt = S_RUN;
        else if (w_cnt_nxt == 2'd0)
          w_state_nxt = S_HALT;
      end
      S_HALT: begin
        if (!HALT_REQ)
          w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // State register with HALTED registered alongside it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_RUN;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_halted <= (w_state_nxt == S_HALT);
    end
  end

  // PC, occupancy and head pointer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc   <= RESET_PC;
      r_cnt  <= 2'd0;
      r_head <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (REDIRECT) begin
        r_pc   <= REDIRECT_PC;
        r_head <= 1'b0;
      end else begin
        if (w_push)
          r_pc <= r_pc + 1'b1;
        if (w_pop)
          r_head <= ~r_head;
      end
    end
  end

  // Buffer slots; contents are masked at the output when empty.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_bpc[w_tail]    <= r_pc;
      r_binstr[w_tail] <= IMRD;
    end
  end

  assign IMA          = r_pc;
  assign HALTED       = r_halted;
  assign dec.IF_VALID = w_valid;
  assign dec.IF_PC    = w_valid ? r_bpc[r_head]    : '0;
  assign dec.IF_INSTR = w_valid ? r_binstr[r_head] : '0;

endmodule
